timer_counter: RTL and testbench

- Memory-mapped countdown timer on the processor's peripheral bus, directly downstream of the CPU core.
- The system bridge decodes the CPU's peripheral address, write-enable and write-data and drives this block's select, offset, write strobe and data.
- It returns read data to the bridge, which feeds it back as the CPU's peripheral read bus.
- Its interrupt output drives one bit of the CPU's six-bit hardware interrupt vector.

---
 rtl/timer_counter_pkg.sv | 25 ++
 rtl/timer_counter.sv | 132 +++++++++++++
 tb/tb_timer_counter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the countdown timer peripheral: register map,
// CTRL bit positions, mode codes and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT register file, sequencing
// FSM and combinational read mux in one flat module.
//
// state | meaning
// IDLE  | COUNT holds; waits for EN
// LOAD  | COUNT takes PRESET
// CNT   | COUNT decrements toward zero; EN=0 aborts to IDLE
// INT   | expiry: one-shot clears EN, auto-reload re-enters LOAD
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  logic              irq_flag;
  state_t            state;
  state_t            state_nx;

  logic wr_ctrl;
  logic wr_preset;
  logic en;
  logic reload;
  logic cnt_zero;
  logic do_load;
  logic do_dec;
  logic do_set;
  logic do_clr;
  logic do_en_clr;
  logic unused_wd;

  assign wr_ctrl   = sel & we & (addr == OFF_CTRL);
  assign wr_preset = sel & we & (addr == OFF_PRESET);
  assign en        = ctrl[CTRL_EN];
  assign reload    = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign cnt_zero  = (count == '0);
  assign unused_wd = ^wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (en) state_nx = LOAD;
      LOAD: state_nx = CNT;
      CNT: begin
        if (!en)          state_nx = IDLE;
        else if (cnt_zero) state_nx = INT;
      end
      INT: state_nx = reload ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    do_load   = 1'b0;
    do_dec    = 1'b0;
    do_set    = 1'b0;
    do_clr    = 1'b0;
    do_en_clr = 1'b0;
    case (state)
      LOAD: do_load = 1'b1;
      CNT: begin
        if (en) begin
          if (cnt_zero) do_set = 1'b1;
          else          do_dec = 1'b1;
        end
      end
      INT: begin
        if (reload) do_clr    = 1'b1;
        else        do_en_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // A CPU write to CTRL overrides the one-shot EN clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= wd[CTRL_W-1:0];
    end else if (do_en_clr) begin
      ctrl[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         preset <= '0;
    else if (wr_preset) preset <= wd[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       count <= '0;
    else if (do_load) count <= preset;
    else if (do_dec)  count <= count - CNT_W'(1);
  end

  // Expiry takes priority over a coincident register write so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 irq_flag <= 1'b0;
    else if (do_set)                            irq_flag <= 1'b1;
    else if (do_clr || wr_ctrl || wr_preset)    irq_flag <= 1'b0;
  end

  assign irq = irq_flag & ctrl[CTRL_IM];

  always_comb begin
    rd = '0;
    case (addr)
      OFF_CTRL:   rd[CTRL_W-1:0] = ctrl;
      OFF_PRESET: rd[CNT_W-1:0]  = preset;
      OFF_COUNT:  rd[CNT_W-1:0]  = count;
      default:    rd = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, auto-reload, masking,
// mid-count PRESET update, CTRL write collision and ignored offsets.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_pass;
  int n_total;

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel  = 1'b1;
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we  = 1'b0;
    wd  = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    #2;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), v);
      n_total++;
      if (v !== 32'h0) $display("FAIL reset_rd addr=%0d got %0h exp 0", a, v);
      else n_pass++;
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1);
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'h1);
    step(5);
    read_reg(2'd2, v);
    n_total++;
    if (v !== 32'd7) $display("FAIL midcount_pre_reset got %0d exp 7", v);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (rd !== 32'h0) $display("FAIL async_reset_count got %0h exp 0", rd);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL async_reset_irq got %b exp 0", irq);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(3);
    read_reg(2'd0, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL post_reset_ctrl got %0h exp 0", v);
    else n_pass++;
    read_reg(2'd1, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL post_reset_preset got %0h exp 0", v);
    else n_pass++;
    read_reg(2'd2, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL post_reset_count got %0h exp 0", v);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'h9);
    step(1);
    for (int k = 2; k <= 5; k++) begin
      step(1);
      read_reg(2'd2, v);
      n_total++;
      if (v !== 32'(5 - k)) $display("FAIL oneshot_count edge=%0d got %0d exp %0d", k, v, 5 - k);
      else n_pass++;
      n_total++;
      if (irq !== 1'b0) $display("FAIL oneshot_irq_early edge=%0d got %b exp 0", k, irq);
      else n_pass++;
    end
    step(1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL oneshot_irq_rise got %b exp 1", irq);
    else n_pass++;
    step(1);
    read_reg(2'd0, v);
    n_total++;
    if (v !== 32'h8) $display("FAIL oneshot_ctrl_after got %0h exp 8", v);
    else n_pass++;
    step(3);
    n_total++;
    if (irq !== 1'b1) $display("FAIL oneshot_irq_hold got %b exp 1", irq);
    else n_pass++;
    bus_write(2'd0, 32'h8);
    n_total++;
    if (irq !== 1'b0) $display("FAIL oneshot_irq_clear got %b exp 0", irq);
    else n_pass++;
  endtask

  task automatic test_reload();
    logic [31:0] v;
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      n_total++;
      if (irq !== (k % 5 == 0)) $display("FAIL reload_irq edge=%0d got %b exp %b", k, irq, (k % 5 == 0));
      else n_pass++;
      if (k % 5 == 2) begin
        read_reg(2'd2, v);
        n_total++;
        if (v !== 32'd2) $display("FAIL reload_count edge=%0d got %0d exp 2", k, v);
        else n_pass++;
      end
    end
    bus_write(2'd0, 32'h0);
    step(3);
  endtask

  task automatic test_mask();
    logic [31:0] v;
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      n_total++;
      if (irq !== 1'b0) $display("FAIL mask_irq edge=%0d got %b exp 0", k, irq);
      else n_pass++;
    end
    read_reg(2'd0, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL mask_ctrl_en_cleared got %0h exp 0", v);
    else n_pass++;
    bus_write(2'd0, 32'h8);
    n_total++;
    if (irq !== 1'b0) $display("FAIL mask_flag_cleared got %b exp 0", irq);
    else n_pass++;
    step(2);
    n_total++;
    if (irq !== 1'b0) $display("FAIL mask_flag_stays_clear got %b exp 0", irq);
    else n_pass++;
    bus_write(2'd0, 32'h0);
  endtask

  task automatic test_preset_midcount();
    logic [31:0] v;
    bus_write(2'd1, 32'd6);
    bus_write(2'd0, 32'hB);
    step(4);
    read_reg(2'd2, v);
    n_total++;
    if (v !== 32'd4) $display("FAIL mid_count_before got %0d exp 4", v);
    else n_pass++;
    bus_write(2'd1, 32'd9);
    for (int k = 3; k >= 0; k--) begin
      read_reg(2'd2, v);
      n_total++;
      if (v !== 32'(k)) $display("FAIL mid_count_undisturbed got %0d exp %0d", v, k);
      else n_pass++;
      if (k > 0) step(1);
    end
    read_reg(2'd1, v);
    n_total++;
    if (v !== 32'd9) $display("FAIL mid_preset_readback got %0d exp 9", v);
    else n_pass++;
    step(1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL mid_irq got %b exp 1", irq);
    else n_pass++;
    step(2);
    read_reg(2'd2, v);
    n_total++;
    if (v !== 32'd9) $display("FAIL mid_reload_value got %0d exp 9", v);
    else n_pass++;
    bus_write(2'd0, 32'h0);
    step(3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'h9);
    step(3);
    n_total++;
    if (irq !== 1'b1) $display("FAIL b2b_preset0_irq got %b exp 1", irq);
    else n_pass++;
    bus_write(2'd0, 32'h9);
    read_reg(2'd0, v);
    n_total++;
    if (v !== 32'h9) $display("FAIL b2b_ctrl_wins got %0h exp 9", v);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL b2b_write_clears_flag got %b exp 0", irq);
    else n_pass++;
    step(2);
    n_total++;
    if (irq !== 1'b0) $display("FAIL b2b_restart_load got %b exp 0", irq);
    else n_pass++;
    step(1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL b2b_restart_irq got %b exp 1", irq);
    else n_pass++;
    step(1);
    read_reg(2'd0, v);
    n_total++;
    if (v !== 32'h8) $display("FAIL b2b_ctrl_final got %0h exp 8", v);
    else n_pass++;
  endtask

  task automatic test_offsets();
    logic [31:0] v;
    bus_write(2'd1, 32'd5);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    read_reg(2'd0, v);
    n_total++;
    if (v !== 32'h8) $display("FAIL off_ctrl_unchanged got %0h exp 8", v);
    else n_pass++;
    read_reg(2'd1, v);
    n_total++;
    if (v !== 32'd5) $display("FAIL off_preset_unchanged got %0h exp 5", v);
    else n_pass++;
    read_reg(2'd2, v);
    n_total++;
    if (v !== 32'd0) $display("FAIL off_count_unchanged got %0h exp 0", v);
    else n_pass++;
    step(1);
    read_reg(2'd3, v);
    n_total++;
    if (v !== 32'h0) $display("FAIL off3_reads_zero got %0h exp 0", v);
    else n_pass++;
    sel  = 1'b0;
    we   = 1'b1;
    addr = 2'd1;
    wd   = 32'd77;
    step(1);
    we = 1'b0;
    wd = '0;
    read_reg(2'd1, v);
    n_total++;
    if (v !== 32'd5) $display("FAIL unselected_write got %0d exp 5", v);
    else n_pass++;
    bus_write(2'd0, 32'hFFFF_FFF8);
    read_reg(2'd0, v);
    n_total++;
    if (v !== 32'h8) $display("FAIL ctrl_upper_ignored got %0h exp 8", v);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    sel     = 1'b0;
    we      = 1'b0;
    addr    = 2'd0;
    wd      = '0;
    reset   = 1'b0;
    test_reset();
    test_oneshot();
    test_reload();
    test_mask();
    test_preset_midcount();
    test_back_to_back();
    test_offsets();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
